dma_timing_control: RTL

- Bus-cycle sequencer directly downstream of the DMA priority encoder in the 8237A-style controller.
- Accepts one granted channel at a time and requests the bus via HRQ/HLDA, then runs 8237 state timing (SI, S0, S1, S2, S3, SW, S4).
- Drives address, strobes and read/write commands, and returns updated address, count, TC and mask information to the register file.
- DREQ/DACK polarity is handled outside this block; all channel-side signals here are active-high.

---
 rtl/dma_timing_control_if.sv | 56 +++++
 rtl/dma_timing_control.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dma_timing_control_if.sv
// Bus bundle between the DMA priority stage, register file and 8237 timing block.
// master = timing block side, slave = surrounding controller / system bus side.
interface dma_timing_control_if #(
   parameter int AW = 16,
   parameter int CW = 16
);
   // grant side, from the priority encoder and register file
   logic          ctrl_disable;
   logic          grant_valid;
   logic [1:0]    grant_ch;
   logic          dreq_active;
   logic [5:0]    ch_mode;
   logic [AW-1:0] cur_addr;
   logic [CW-1:0] cur_count;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] base_count;
   // system bus side
   logic          HLDA;
   logic          READY;
   logic          EOP_N_in;
   logic          HRQ;
   logic          AEN;
   logic          ADSTB;
   logic [AW-1:0] addr_out;
   logic [3:0]    DACK;
   logic          MEMR_N;
   logic          MEMW_N;
   logic          IOR_N;
   logic          IOW_N;
   logic          EOP_N_out;
   // write-back to the register file
   logic          wb_valid;
   logic [1:0]    wb_ch;
   logic [AW-1:0] wb_addr;
   logic [CW-1:0] wb_count;
   logic [3:0]    tc_set;
   logic [3:0]    mask_set;

   modport master (
      input  ctrl_disable, grant_valid, grant_ch, dreq_active,
      input  ch_mode, cur_addr, cur_count, base_addr, base_count,
      input  HLDA, READY, EOP_N_in,
      output HRQ, AEN, ADSTB, addr_out, DACK,
      output MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_out,
      output wb_valid, wb_ch, wb_addr, wb_count, tc_set, mask_set
   );

   modport slave (
      output ctrl_disable, grant_valid, grant_ch, dreq_active,
      output ch_mode, cur_addr, cur_count, base_addr, base_count,
      output HLDA, READY, EOP_N_in,
      input  HRQ, AEN, ADSTB, addr_out, DACK,
      input  MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_out,
      input  wb_valid, wb_ch, wb_addr, wb_count, tc_set, mask_set
   );
endinterface

// File: rtl/dma_timing_control.sv
// 8237-style bus-cycle sequencer: takes one granted channel, runs SI..S4 timing.
// Ports: CLK, RESET (sync, active-high), bus (master modport: grant, bus, write-back).
module dma_timing_control #(
   parameter int AW = 16,
   parameter int CW = 16
) (
   input logic                 CLK,
   input logic                 RESET,
   dma_timing_control_if.master bus
);
   typedef enum logic [2:0] {
      SI, S0, S1, S2, S3, SW, S4, SC
   } state_t;

   state_t        state, nxt;
   logic [1:0]    ch_q;
   logic [5:0]    mode_q;
   logic [AW-1:0] addr_q, baddr_q;
   logic [CW-1:0] count_q, bcount_q;
   logic          eop_q, end_q;

   logic          accept, tc, end_c, go_s4;
   logic          rd_act, wr_act;
   logic [3:0]    ch_oh;
   logic [AW-1:0] addr_nx;
   logic [CW-1:0] count_nx;

   always_ff @(posedge CLK) begin
      if (RESET) state <= SI;
      else       state <= nxt;
   end

   always_comb begin
      accept   = bus.grant_valid && !bus.ctrl_disable;
      ch_oh    = 4'b0001 << ch_q;
      tc       = (count_q == '0);
      addr_nx  = mode_q[3] ? addr_q - AW'(1) : addr_q + AW'(1);
      count_nx = count_q - CW'(1);
      // external EOP sampled on the edge into S4 still ends this transfer
      end_c    = tc || eop_q || !bus.EOP_N_in;
      nxt      = state;
      unique case (state)
         SI: if (accept) nxt = S0;
         S0: begin
            if (bus.HLDA)
               nxt = (mode_q[5:4] == 2'b11) ? SC : S1;
            else if (!bus.dreq_active)
               nxt = SI;
         end
         SC: if (!bus.dreq_active) nxt = SI;
         S1: nxt = S2;
         S2: nxt = S3;
         S3: nxt = bus.READY ? S4 : SW;
         SW: if (bus.READY) nxt = S4;
         S4: begin
            if (end_q || mode_q[5:4] == 2'b01 ||
                (mode_q[5:4] == 2'b00 && !bus.dreq_active))
               nxt = SI;
            // new upper address byte needs an ADSTB cycle
            else if (addr_nx[AW-1:8] != addr_q[AW-1:8])
               nxt = S1;
            else
               nxt = S2;
         end
         default: nxt = SI;
      endcase
      go_s4  = (nxt == S4);
      rd_act = nxt inside {S2, S3, SW};
      wr_act = nxt inside {S3, SW};
   end

   // channel context and registered outputs, all keyed to the state being entered
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ch_q         <= '0;
         mode_q       <= '0;
         addr_q       <= '0;
         count_q      <= '0;
         baddr_q      <= '0;
         bcount_q     <= '0;
         eop_q        <= 1'b0;
         end_q        <= 1'b0;
         bus.HRQ      <= 1'b0;
         bus.AEN      <= 1'b0;
         bus.ADSTB    <= 1'b0;
         bus.DACK     <= '0;
         bus.addr_out <= '0;
         bus.MEMR_N   <= 1'b1;
         bus.MEMW_N   <= 1'b1;
         bus.IOR_N    <= 1'b1;
         bus.IOW_N    <= 1'b1;
         bus.EOP_N_out <= 1'b1;
         bus.wb_valid <= 1'b0;
         bus.wb_ch    <= '0;
         bus.wb_addr  <= '0;
         bus.wb_count <= '0;
         bus.tc_set   <= '0;
         bus.mask_set <= '0;
      end else begin
         if (state == SI && accept) begin
            ch_q     <= bus.grant_ch;
            mode_q   <= bus.ch_mode;
            addr_q   <= bus.cur_addr;
            count_q  <= bus.cur_count;
            baddr_q  <= bus.base_addr;
            bcount_q <= bus.base_count;
         end
         if (state inside {S2, S3, SW} && !bus.EOP_N_in)
            eop_q <= 1'b1;
         if (go_s4)
            end_q <= end_c;
         if (state == S4) begin
            eop_q <= 1'b0;
            if (end_q && mode_q[2]) begin
               addr_q  <= baddr_q;
               count_q <= bcount_q;
            end else begin
               addr_q  <= addr_nx;
               count_q <= count_nx;
            end
         end
         bus.HRQ   <= (nxt != SI);
         bus.AEN   <= nxt inside {S1, S2, S3, SW, S4};
         bus.ADSTB <= (nxt == S1);
         bus.DACK  <= (nxt inside {S1, S2, S3, SW, S4, SC}) ?
                      ch_oh : 4'b0000;
         if (nxt == S1 || nxt == S2)
            bus.addr_out <= (state == S4) ? addr_nx : addr_q;
         bus.IOR_N  <= !(rd_act && mode_q[1:0] == 2'b01);
         bus.MEMR_N <= !(rd_act && mode_q[1:0] == 2'b10);
         bus.MEMW_N <= !(wr_act && mode_q[1:0] == 2'b01);
         bus.IOW_N  <= !(wr_act && mode_q[1:0] == 2'b10);
         bus.wb_valid <= go_s4;
         bus.wb_ch    <= ch_q;
         bus.wb_addr  <= (end_c && mode_q[2]) ? baddr_q : addr_nx;
         bus.wb_count <= (end_c && mode_q[2]) ? bcount_q : count_nx;
         bus.tc_set   <= (go_s4 && tc) ? ch_oh : 4'b0000;
         bus.mask_set <= (go_s4 && end_c && !mode_q[2]) ?
                         ch_oh : 4'b0000;
         bus.EOP_N_out <= !(go_s4 && tc);
      end
   end
endmodule
